// File: rtl/alu_seq_pkg.sv
// Opcode values and FSM state encoding shared by the sequential ALU and its
// iterative multiplier.
package alu_seq_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_NOR = 5;
  localparam int unsigned OP_SRA = 6;
  localparam int unsigned OP_SRL = 7;
  localparam int unsigned OP_SLL = 8;
  localparam int unsigned OP_MUL = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle, NB_DATA cycles
// from the i_start edge until the full product is held with o_done raised.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [NB_DATA-1:0]     i_a,
  input  logic [NB_DATA-1:0]     i_b,
  output logic                   o_done,
  output logic [2*NB_DATA-1:0]   o_product
);

  localparam int CNT_W = $clog2(NB_DATA);

  logic                 busy_q;
  logic                 done_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NB_DATA-1:0]   mcand_q;
  logic [2*NB_DATA-1:0] prod_q;

  // Upper half accumulates the multiplicand when the current multiplier LSB is
  // set; the whole register then shifts right, carrying the add's carry-out in.
  function automatic logic [2*NB_DATA-1:0] mul_step(
    input logic [2*NB_DATA-1:0] prod,
    input logic [NB_DATA-1:0]   mcand
  );
    logic [NB_DATA:0] upper;
    upper = {1'b0, prod[2*NB_DATA-1:NB_DATA]} + (prod[0] ? {1'b0, mcand} : '0);
    return {upper, prod[NB_DATA-1:1]};
  endfunction

  // The first step is folded into the load so the product is complete on the
  // (NB_DATA-1)th edge after start and the parent can capture it on the next.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_start) begin
        mcand_q <= i_a;
        prod_q  <= mul_step({{NB_DATA{1'b0}}, i_b}, i_a);
        cnt_q   <= CNT_W'(NB_DATA - 1);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        prod_q <= mul_step(prod_q, mcand_q);
        cnt_q  <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign o_done    = done_q;
  assign o_product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: operands and opcode loaded over a shared bus, launched with
// i_start, result and status flags held until the next o_valid pulse.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_OP   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_load_a,
  input  logic               i_load_b,
  input  logic               i_load_op,
  input  logic               i_start,
  output logic               o_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_err
);

  localparam int SHW = $clog2(NB_DATA);
  localparam int MSB = NB_DATA - 1;

  state_e               state_q;
  logic [NB_DATA-1:0]   a_q, b_q;
  logic [NB_OP-1:0]     op_q;
  logic [NB_DATA-1:0]   xa_q, xb_q;
  logic [NB_OP-1:0]     xop_q;
  logic                 ready_q, valid_q;
  logic [NB_DATA-1:0]   result_q;
  logic                 zero_q, carry_q, ovf_q, err_q;

  logic [NB_DATA-1:0]   result_d;
  logic                 zero_d, carry_d, ovf_d, err_d;
  logic [NB_DATA:0]     add_x, sub_x;
  logic signed [NB_DATA-1:0] xa_s;
  logic [SHW-1:0]       sh_amt;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*NB_DATA-1:0] mul_prod;

  // The multiplier samples the held (pre-load) operands on the launch edge.
  assign mul_start = (state_q == S_IDLE) && i_start && (op_q == NB_OP'(OP_MUL));

  alu_mul_iter #(
    .NB_DATA (NB_DATA)
  ) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (mul_start),
    .i_a       (a_q),
    .i_b       (b_q),
    .o_done    (mul_done),
    .o_product (mul_prod)
  );

  assign add_x  = {1'b0, xa_q} + {1'b0, xb_q};
  assign sub_x  = {1'b0, xa_q} - {1'b0, xb_q};
  assign xa_s   = xa_q;
  assign sh_amt = xb_q[SHW-1:0];
  assign is_mul = (xop_q == NB_OP'(OP_MUL));

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    err_d    = 1'b0;
    case (xop_q)
      NB_OP'(OP_ADD): begin
        result_d = add_x[NB_DATA-1:0];
        carry_d  = add_x[NB_DATA];
        ovf_d    = (xa_q[MSB] == xb_q[MSB]) && (add_x[MSB] != xa_q[MSB]);
      end
      NB_OP'(OP_SUB): begin
        result_d = sub_x[NB_DATA-1:0];
        carry_d  = ~sub_x[NB_DATA];
        ovf_d    = (xa_q[MSB] != xb_q[MSB]) && (sub_x[MSB] != xa_q[MSB]);
      end
      NB_OP'(OP_AND): result_d = xa_q & xb_q;
      NB_OP'(OP_OR):  result_d = xa_q | xb_q;
      NB_OP'(OP_XOR): result_d = xa_q ^ xb_q;
      NB_OP'(OP_NOR): result_d = ~(xa_q | xb_q);
      NB_OP'(OP_SRA): result_d = xa_s >>> sh_amt;
      NB_OP'(OP_SRL): result_d = xa_q >> sh_amt;
      NB_OP'(OP_SLL): result_d = xa_q << sh_amt;
      NB_OP'(OP_MUL): begin
        result_d = mul_prod[NB_DATA-1:0];
        ovf_d    = |mul_prod[2*NB_DATA-1:NB_DATA];
      end
      default:        err_d = 1'b1;
    endcase
  end

  assign zero_d = (result_d == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      xa_q     <= '0;
      xb_q     <= '0;
      xop_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_load_a)  a_q  <= i_data;
          if (i_load_b)  b_q  <= i_data;
          if (i_load_op) op_q <= i_data[NB_OP-1:0];
          // Snapshot is taken from the pre-load values so a coincident load
          // only affects the following operation.
          if (i_start) begin
            xa_q    <= a_q;
            xb_q    <= b_q;
            xop_q   <= op_q;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!is_mul || mul_done) begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_zero     = zero_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (NB_DATA=16): directed vectors plus random
// operations checked against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic        load_a = 1'b0, load_b = 1'b0, load_op = 1'b0, start = 1'b0;
  logic        ready, valid;
  logic [15:0] result;
  logic        zero, carry, ovf, err;
  logic [19:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.NB_DATA(16), .NB_OP(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_load_a   (load_a),
    .i_load_b   (load_b),
    .i_load_op  (load_op),
    .i_start    (start),
    .o_ready    (ready),
    .o_valid    (valid),
    .o_result   (result),
    .o_zero     (zero),
    .o_carry    (carry),
    .o_overflow (ovf),
    .o_err      (err)
  );

  assign obs = {result, zero, carry, ovf, err};

  // Reference: {result[15:0], zero, carry, overflow, err}
  function automatic logic [19:0] model(input int unsigned a, input int unsigned b,
                                        input int unsigned op);
    logic [31:0] r;
    bit c, v, e;
    int sa, sb, s;
    int unsigned sh;
    longint unsigned p;
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    sh = b % 16;
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      0: begin r = (a + b) % 65536; c = (a + b) >= 65536; s = sa + sb;
               v = (s > 32767) || (s < -32768); end
      1: begin r = (a + 65536 - b) % 65536; c = (a >= b); s = sa - sb;
               v = (s > 32767) || (s < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~(a | b) & 32'hFFFF;
      6: begin s = sa >>> sh; r = 32'(s) & 32'hFFFF; end
      7: r = a >> sh;
      8: r = (a << sh) % 65536;
      9: begin p = longint'(a) * longint'(b); r = 32'(p % 65536); v = (p >= 65536); end
      default: e = 1;
    endcase
    return {r[15:0], (r == 0), c, v, e};
  endfunction

  task automatic wait_ready;
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", ready, n);
    end
  endtask

  task automatic load(input bit la, input bit lb, input bit lo, input logic [15:0] d);
    wait_ready();
    data = d; load_a = la; load_b = lb; load_op = lo;
    @(posedge clk); #1;
    load_a = 0; load_b = 0; load_op = 0;
  endtask

  // Returns the number of edges from the start edge to o_valid, -1 on timeout.
  task automatic launch(output int lat);
    wait_ready();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       output int lat);
    load(1, 0, 0, a);
    load(0, 1, 0, b);
    load(0, 0, 1, {12'h0, op});
    launch(lat);
  endtask

  task automatic test_reset;
    int lat;
    rst_n = 0; data = 16'hFFFF; load_a = 1; load_b = 1; load_op = 1; start = 1;
    repeat (3) @(posedge clk);
    #1;
    load_a = 0; load_b = 0; load_op = 0; start = 0;
    checks++;
    if ({ready, valid} !== 2'b10) begin
      errors++; $display("FAIL reset_ctrl: ready/valid=%b, required 10", {ready, valid});
    end
    checks++;
    if (obs !== 20'h0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 00000", obs);
    end
    rst_n = 1;
    launch(lat);
    checks++;
    if (lat !== 1 || obs !== {16'h0, 4'b1000}) begin
      errors++; $display("FAIL reset_regs_cleared: lat=%0d obs=%h, required lat=1 obs=%h",
                         lat, obs, {16'h0, 4'b1000});
    end
  endtask

  task automatic test_arith;
    int lat;
    do_op(16'd6, 16'd4, 4'd0, lat);
    checks++;
    if (lat !== 1 || obs !== {16'd10, 4'b0000}) begin
      errors++; $display("FAIL add_6_4: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'd10, 4'b0});
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || result !== 16'd10) begin
      errors++; $display("FAIL valid_pulse: valid=%b result=%h, required 0 and 000a", valid, result);
    end
    do_op(16'd4, 16'd6, 4'd1, lat);
    checks++;
    if (lat !== 1 || obs !== {16'hFFFE, 4'b0000}) begin
      errors++; $display("FAIL sub_4_6: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'hFFFE, 4'b0});
    end
    do_op(16'h7FFF, 16'd1, 4'd0, lat);
    checks++;
    if (lat !== 1 || obs !== {16'h8000, 4'b0010}) begin
      errors++; $display("FAIL add_ovf: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'h8000, 4'b0010});
    end
  endtask

  task automatic test_mul;
    int lat;
    load(1, 0, 0, 16'd6); load(0, 1, 0, 16'd4); load(0, 0, 1, 16'd9);
    wait_ready();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin start = 1; load_a = 1; data = 16'd9; end
      else begin start = 0; load_a = 0; end
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    start = 0; load_a = 0;
    checks++;
    if (lat !== 16 || obs !== {16'd24, 4'b0000}) begin
      errors++; $display("FAIL mul_6_4: lat=%0d obs=%h, required lat=16 obs=%h", lat, obs, {16'd24, 4'b0});
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL mul_no_requeue: valid=%b, required 0", valid);
    end
    load(0, 0, 1, 16'd0);
    launch(lat);
    checks++;
    if (lat !== 1 || result !== 16'd10) begin
      errors++; $display("FAIL a_kept_after_mul: lat=%0d result=%h, required lat=1 result=000a", lat, result);
    end
    do_op(16'h0100, 16'h0100, 4'd9, lat);
    checks++;
    if (lat !== 16 || obs !== {16'h0, 4'b1010}) begin
      errors++; $display("FAIL mul_ovf: lat=%0d obs=%h, required lat=16 obs=%h", lat, obs, {16'h0, 4'b1010});
    end
    load(0, 0, 1, 16'h000F);
    launch(lat);
    checks++;
    if (lat !== 1 || obs !== {16'h0, 4'b1001}) begin
      errors++; $display("FAIL invalid_op: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'h0, 4'b1001});
    end
  endtask

  task automatic test_reset_mid_mul;
    int seen = 0;
    load(1, 0, 0, 16'd6); load(0, 1, 0, 16'd4); load(0, 0, 1, 16'd9);
    wait_ready();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if ({ready, valid} !== 2'b10 || obs !== 20'h0) begin
      errors++; $display("FAIL reset_mid_mul: ready/valid=%b obs=%h, required 10 and 00000",
                         {ready, valid}, obs);
    end
    repeat (25) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL aborted_no_valid: %0d valid pulses, required 0", seen);
    end
  endtask

  task automatic test_shifts;
    int lat;
    do_op(16'h8000, 16'h0013, 4'd6, lat);
    checks++;
    if (lat !== 1 || obs !== {16'hF000, 4'b0000}) begin
      errors++; $display("FAIL sra: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'hF000, 4'b0});
    end
    do_op(16'h8000, 16'h0013, 4'd7, lat);
    checks++;
    if (lat !== 1 || obs !== {16'h1000, 4'b0000}) begin
      errors++; $display("FAIL srl: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'h1000, 4'b0});
    end
    do_op(16'h8000, 16'h0013, 4'd8, lat);
    checks++;
    if (lat !== 1 || obs !== {16'h0000, 4'b1000}) begin
      errors++; $display("FAIL sll: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'h0, 4'b1000});
    end
  endtask

  task automatic test_load_with_start;
    int lat;
    do_op(16'd1, 16'd2, 4'd0, lat);
    wait_ready();
    data = 16'h0010; load_a = 1; start = 1;
    @(posedge clk); #1;
    load_a = 0; start = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    checks++;
    if (lat !== 1 || result !== 16'd3) begin
      errors++; $display("FAIL load_start_preload: lat=%0d result=%h, required lat=1 result=0003", lat, result);
    end
    launch(lat);
    checks++;
    if (lat !== 1 || result !== 16'h0012) begin
      errors++; $display("FAIL load_start_applied: lat=%0d result=%h, required lat=1 result=0012", lat, result);
    end
    load(1, 1, 1, 16'h0004);
    launch(lat);
    checks++;
    if (lat !== 1 || obs !== {16'h0, 4'b1000}) begin
      errors++; $display("FAIL multi_strobe: lat=%0d obs=%h, required lat=1 obs=%h", lat, obs, {16'h0, 4'b1000});
    end
  endtask

  task automatic test_back_to_back;
    int cnt = 0;
    load(1, 1, 1, 16'h0000);
    wait_ready();
    start = 1;
    repeat (9) begin
      @(posedge clk); #1;
      if (valid) cnt++;
    end
    start = 0;
    checks++;
    if (cnt !== 3) begin
      errors++; $display("FAIL back_to_back: %0d valid pulses in 9 cycles, required 3", cnt);
    end
  endtask

  task automatic test_random;
    int lat;
    int unsigned a, b, op;
    logic [19:0] exp;
    for (int n = 0; n < 40; n++) begin
      a  = $urandom_range(0, 65535);
      b  = (n % 3 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 65535);
      op = (n < 10) ? 32'(n) : $urandom_range(0, 15);
      exp = model(a, b, op);
      do_op(16'(a), 16'(b), 4'(op), lat);
      checks++;
      if (lat !== ((op == 9) ? 16 : 1) || obs !== exp) begin
        errors++; $display("FAIL random op=%0d a=%h b=%h: lat=%0d obs=%h, required lat=%0d obs=%h",
                           op, a, b, lat, obs, (op == 9) ? 16 : 1, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_reset_mid_mul();
    test_shifts();
    test_load_with_start();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NB_DATA, default 16, operand/result width; legal range 4..64.
REQ-002 Parameter NB_OP, default 4, opcode width.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_data  input  NB_DATA  shared load bus for A, B and opcode.
REQ-007 i_load_a  input  1  load i_data into register A.
REQ-008 i_load_b  input  1  load i_data into register B.
REQ-009 i_load_op  input  1  load i_data[NB_OP-1:0] into register OP.
REQ-010 i_start  input  1  launch operation on held A, B, OP.
REQ-011 o_ready  output  1  high only in IDLE; loads and start accepted.
REQ-012 o_valid  output  1  one-cycle pulse; o_result and flags updated.
REQ-013 o_result  output  NB_DATA  last computed result, held until next o_valid.
REQ-014 o_zero, o_carry, o_overflow, o_err  output  1 each  status flags, held with o_result.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, DONE.
REQ-016 IDLE: i_start=1 -> EXEC, operands frozen; i_start=0 -> stay.
REQ-017 EXEC: single-cycle ops -> DONE after 1 cycle; MUL -> DONE after exactly NB_DATA cycles.
REQ-018 DONE: o_valid=1 for that one cycle, unconditional -> IDLE.
REQ-019 Latency: start sampled at edge k; o_valid high after edge k+1 (single-cycle) or edge k+NB_DATA (MUL).
REQ-020 Loads SHALL take effect only in IDLE; any load in EXEC/DONE is discarded.
REQ-021 Simultaneous load and start in IDLE: operation uses pre-load values; load still applied at that edge for next operation.
REQ-022 Multiple load strobes in one cycle SHALL all load from i_data.
REQ-023 i_start in EXEC or DONE SHALL be ignored (no queuing).
REQ-024 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SRA, 7 SRL, 8 SLL, 9 MUL (unsigned, low NB_DATA bits).
REQ-025 Shift amount SHALL be B[$clog2(NB_DATA)-1:0]; upper B bits ignored.
REQ-026 Opcodes 10..2^NB_OP-1: o_result=0, o_err=1, other flags 0, single-cycle latency.
REQ-027 o_zero = (o_result==0) for every opcode including invalid.
REQ-028 o_carry: ADD carry-out; SUB no-borrow (A>=B unsigned); 0 otherwise.
REQ-029 o_overflow: ADD/SUB signed two's-complement overflow; MUL nonzero upper NB_DATA product bits; 0 otherwise.
REQ-030 Arithmetic SHALL be NB_DATA wide with one extra bit for carry; no truncation warnings.

Reset
REQ-031 i_rst_n=0 at an edge: state IDLE, A=B=OP=0, multiplier cleared, o_result=0, all flags 0, o_valid=0, o_ready=1 after that edge.
REQ-032 Reset during EXEC (incl. mid-MUL) SHALL abort; no o_valid pulse for the aborted operation.
REQ-033 Reset SHALL dominate any concurrent load or start.

Structure
REQ-034 Package alu_seq_pkg SHALL hold opcode localparams and FSM state encoding.
REQ-035 Iterative shift-add multiplier SHALL be sub-module alu_mul_iter (start/done, NB_DATA-cycle).
REQ-036 Combinational datapath and flag logic SHALL remain in alu_seq.

Verification (NB_DATA=16)
REQ-037 Load A=6, B=4, OP=0, start -> o_valid after edge k+1, o_result=10, all flags 0.
REQ-038 A=4, B=6, OP=1 -> 0xFFFE, carry 0; A=0x7FFF, B=1, OP=0 -> 0x8000, overflow 1, carry 0.
REQ-039 A=6, B=4, OP=9 -> 24 after edge k+16; A=B=0x0100, OP=9 -> 0x0000, zero 1, overflow 1.
REQ-040 Start and load A=9 during MUL -> ignored, result unchanged, A still 6; OP=0xF -> result 0, err 1.
REQ-041 Reset at edge k+5 of MUL -> no o_valid, o_result 0, o_ready 1 next cycle.
REQ-042 A=0x8000, B=0x0013, OP=6 -> 0xF000 (shift 3); OP=7 -> 0x1000; OP=8 -> 0x0000, zero 1.
